inv_mix_columns_iter: RTL
=========================

# inv_mix_columns_iter

Iterative AES InvMixColumns stage for the decryption datapath, the inverse of the encryption MixColumns stage. It accepts one 128-bit state, transforms one column per clock with a shared GF(2^8) multiply-by-{0e,0b,0d,09} datapath, and presents the registered result with a one-cycle `done` pulse. It trades three extra cycles of latency for roughly a quarter of the multiplier area of a fully parallel stage. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
Parameters: none.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: start request; accepted only when `ready`=1.
- `state` input 128: input state; sampled on the accepting edge only.
- `ready` output 1: high when idle and able to accept `en`.
- `state_out` output 128: InvMixColumns result; holds its value until the next completion.
- `done` output 1: one-cycle pulse; `state_out` is valid and new in the same cycle.

## Operation
- Byte layout, matching the codebase: byte (row r, column c) = bits [32*c + 8*r +: 8]. Column c = `state[32*c +: 32]`, and row 0 is its low byte.
- Per column with input bytes a0..a3 (rows 0..3), outputs are:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF(2^8) multiply uses reduction polynomial 0x11b. xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0). Products are built from xtime chains: 09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2. All intermediates are 8 bits and the carry out is discarded.
- Only one column datapath instance exists. A 2-bit column counter `col` selects its input column from the captured work register.
- FSM:
  - IDLE: `ready`=1. On `en`=1, capture `state` into the work register, set `col`=0, and go to RUN.
  - RUN: each cycle, write the transformed column `col` back into the work register and increment `col`. When `col`=3, load `state_out` with the full result (columns 0..2 from the work register plus column 3 from the datapath), set `done`=1, and go to IDLE.
- `en` while `ready`=0 is ignored. It is not queued, and the in-flight operation is unaffected.
- `state` changing during RUN has no effect.
- Reset values: `state_out`=128'h0, `done`=0, `ready`=1, FSM=IDLE, `col`=0, work register=0.
- `rst` asserted mid-operation abandons the operation. No `done` follows, `state_out` returns to 0, and `ready` is 1 in the cycle after the reset edge.
- `rst` has priority over `en` on the same edge.

## Timing
- Accept edge: end of cycle T, with `en`=1 and `ready`=1.
- Columns 0..3 are processed on the edges ending cycles T+1..T+4. `ready`=0 during T+1..T+4.
- `done`=1 and the new `state_out` are visible in cycle T+5 only, which gives a latency of 5 cycles from `en` to `done`.
- `ready`=1 again in T+5. An `en` in T+5 is accepted, so back-to-back throughput is one state per 5 cycles, and `done` and acceptance may coincide.
- `done` is never high for two consecutive cycles.
- `state_out` does not change on any edge except the completion edge and reset.

## Test plan
- Reset: hold `rst` for 2 cycles with `en`=1 -> `state_out`=0, `done`=0, `ready`=1, and no acceptance occurs during reset.
- FIPS-197 columns: give columns 0..3 the input bytes (row0..row3) 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / d5 d5 d7 d6. Expected: `done` exactly 5 cycles after `en`, with output columns db 13 53 45 / f2 0a 22 5c / 01 01 01 01 / d4 d4 d4 d5.
- Round trip: drive 100 random states through a reference MixColumns model, then through this block -> `state_out` equals the original state every time; also check c6 c6 c6 c6 -> c6 c6 c6 c6.
- Busy rejection: pulse `en` with a different `state` in T+2 and T+4 -> exactly one `done` (in T+5) carrying the first state's result, and `ready` low T+1..T+4.
- Back-to-back: hold `en`=1 continuously with new data at each acceptance -> `done` pulses every 5 cycles with the correct results and `state_out` stable between pulses.
- Mid-op reset: assert `rst` in T+3 -> no `done`, `state_out`=0, and `ready`=1 the following cycle. A new `en` afterwards completes correctly in 5 cycles.

Source files
------------

// File: rtl/inv_mix_columns_iter_if.sv
// Start/result bundle for the iterative InvMixColumns stage.
// The slave side is the datapath block; the master side is whoever feeds it states.
`timescale 1ns/1ps

interface inv_mix_columns_iter_if;
  logic         en;
  logic [127:0] state;
  logic         ready;
  logic [127:0] state_out;
  logic         done;

  modport slave (
    input  en,
    input  state,
    output ready,
    output state_out,
    output done
  );

  modport master (
    output en,
    output state,
    input  ready,
    input  state_out,
    input  done
  );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one shared column datapath, one column per clock,
// registered result with a single-cycle done pulse five cycles after acceptance.
`timescale 1ns/1ps

module inv_mix_columns_iter (
  input  logic                  i_clk,
  input  logic                  i_rst,
  inv_mix_columns_iter_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_nextFsm;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [127:0] r_stateOut;
  logic         r_done;

  logic         w_load;
  logic         w_step;
  logic         w_finish;
  logic         w_ready;
  logic [31:0]  w_colIn;
  logic [31:0]  w_colOut;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Each byte needs x2/x4/x8 once; the four constant products are XORs of those.
  function automatic logic [31:0] invMixColumn(input logic [31:0] c);
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    for (int r = 0; r < 4; r++) begin
      a     = c[8*r +: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a;
      mb[r] = x8 ^ x2 ^ a;
      md[r] = x8 ^ x4 ^ a;
      me[r] = x8 ^ x4 ^ x2;
    end
    b0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    b1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    b2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    b3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {b3, b2, b1, b0};
  endfunction

  assign w_colIn  = r_work[{r_col, 5'b00000} +: 32];
  assign w_colOut = invMixColumn(w_colIn);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_nextFsm;
    end
  end

  always_comb begin
    w_nextFsm = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    w_ready   = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.en) begin
          w_load    = 1'b1;
          w_nextFsm = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_col == 2'd3) begin
          w_finish  = 1'b1;
          w_nextFsm = IDLE;
        end
      end
      default: w_nextFsm = IDLE;
    endcase
  end

  // The last column bypasses the work register so the result lands on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col      <= 2'd0;
      r_work     <= 128'h0;
      r_stateOut <= 128'h0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_work <= bus.state;
        r_col  <= 2'd0;
      end else if (w_step) begin
        r_work[{r_col, 5'b00000} +: 32] <= w_colOut;
        r_col                           <= r_col + 2'd1;
      end
      if (w_finish) begin
        r_stateOut <= {w_colOut, r_work[95:0]};
      end
    end
  end

  assign bus.ready     = w_ready;
  assign bus.state_out = r_stateOut;
  assign bus.done      = r_done;

endmodule
